spi_slave_sync: RTL

- Parametrised SPI slave; supersedes the sclk-clocked 8-bit slave.
- Oversamples sclk, mosi and ss into the single system clock, so the whole block lives in one domain.
- Supports all four SPI modes, MSB/LSB-first, configurable word width, and back-to-back words within one ss assertion.
- Exposes valid/ready streams on the TX and RX sides to the peripheral core, with underrun, overrun and abort flags.

---
 rtl/spi_slave_sync.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_sync.sv
// SPI slave, oversampled into clk: all four modes, MSB/LSB first,
// width BitWidth, valid/ready TX and RX streams, error pulses.
// Ports: clk/rst/clk_en; tx_data/tx_valid/tx_ready; rx_data/rx_valid/
// rx_ready; tx_underrun/rx_overrun/frame_abort; busy; sclk/mosi/miso/ss.
module spi_slave_sync #(
  parameter int BitWidth    = 8,
  parameter int MODE        = 0,
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic [BitWidth-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [BitWidth-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                tx_underrun,
  output logic                rx_overrun,
  output logic                frame_abort,
  output logic                busy,
  input  logic                sclk,
  input  logic                mosi,
  output logic                miso,
  input  logic                ss
);
  localparam logic CPOL = (MODE & 2) != 0;
  localparam logic CPHA = (MODE & 1) != 0;
  localparam int   CW   = $clog2(BitWidth);
  localparam logic [CW-1:0] LAST = CW'(BitWidth - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
  logic [SYNC_STAGES-1:0] ss_q, ss_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
  logic                   sclk_h_q, ss_h_q;
  logic [BitWidth-1:0]    hold_q, hold_d;
  logic                   full_q, full_d;
  logic [BitWidth-1:0]    txs_q, txs_d;
  logic [BitWidth-1:0]    rxs_q, rxs_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BitWidth-1:0]    rxd_q, rxd_d;
  logic                   rxv_q, rxv_d;
  logic                   und_q, und_d;
  logic                   ovr_q, ovr_d;
  logic                   abt_q, abt_d;

  logic sclk_s, ss_s, mosi_s;
  logic lead, trail, samp, shft;
  logic ss_fall, ss_rise, act, load;
  logic [BitWidth-1:0] rx_w;

  assign sclk_s  = sclk_q[SYNC_STAGES-1];
  assign ss_s    = ss_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_q[SYNC_STAGES-1];
  assign lead    = (sclk_h_q == CPOL) && (sclk_s != CPOL);
  assign trail   = (sclk_h_q != CPOL) && (sclk_s == CPOL);
  assign samp    = CPHA ? trail : lead;
  assign shft    = CPHA ? lead : trail;
  assign ss_fall = ss_h_q && !ss_s;
  assign ss_rise = !ss_h_q && ss_s;
  assign act     = (state_q == ACTIVE) && !ss_s;
  // CPHA=0 also preloads on select so bit 0 is out before the first edge
  assign load    = (act && shft && cnt_q == '0) || (!CPHA && ss_fall);
  assign rx_w    = (LSB_FIRST != 0) ? {mosi_s, rxs_q[BitWidth-1:1]}
                                    : {rxs_q[BitWidth-2:0], mosi_s};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ss_fall) state_d = ACTIVE;
      ACTIVE:  if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sclk_d = {sclk_q[SYNC_STAGES-2:0], sclk};
    ss_d   = {ss_q[SYNC_STAGES-2:0], ss};
    mosi_d = {mosi_q[SYNC_STAGES-2:0], mosi};
    hold_d = hold_q;
    full_d = full_q;
    txs_d  = txs_q;
    rxs_d  = rxs_q;
    cnt_d  = cnt_q;
    rxd_d  = rxd_q;
    rxv_d  = rxv_q;
    und_d  = 1'b0;
    ovr_d  = 1'b0;
    abt_d  = 1'b0;
    if (tx_valid && !full_q) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end
    if (rxv_q && rx_ready) rxv_d = 1'b0;
    if (ss_rise) begin
      cnt_d = '0;
      txs_d = '0;
      rxs_d = '0;
      abt_d = (cnt_q != '0);
    end else begin
      if (load) begin
        if (full_q) begin
          txs_d  = hold_q;
          full_d = 1'b0;
        end else begin
          txs_d = '0;
          und_d = 1'b1;
        end
      end else if (act && shft) begin
        txs_d = (LSB_FIRST != 0) ? (txs_q >> 1) : (txs_q << 1);
      end
      if (act && samp) begin
        rxs_d = rx_w;
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // a same-cycle consume frees the slot for the new word
          if (!rxv_q || rx_ready) begin
            rxd_d = rx_w;
            rxv_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sclk_q   <= {SYNC_STAGES{CPOL}};
      ss_q     <= '1;
      mosi_q   <= '0;
      sclk_h_q <= CPOL;
      ss_h_q   <= 1'b1;
      hold_q   <= '0;
      full_q   <= 1'b0;
      txs_q    <= '0;
      rxs_q    <= '0;
      cnt_q    <= '0;
      rxd_q    <= '0;
      rxv_q    <= 1'b0;
      und_q    <= 1'b0;
      ovr_q    <= 1'b0;
      abt_q    <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      sclk_q   <= sclk_d;
      ss_q     <= ss_d;
      mosi_q   <= mosi_d;
      sclk_h_q <= sclk_s;
      ss_h_q   <= ss_s;
      hold_q   <= hold_d;
      full_q   <= full_d;
      txs_q    <= txs_d;
      rxs_q    <= rxs_d;
      cnt_q    <= cnt_d;
      rxd_q    <= rxd_d;
      rxv_q    <= rxv_d;
      und_q    <= und_d;
      ovr_q    <= ovr_d;
      abt_q    <= abt_d;
    end
  end

  assign tx_ready    = !full_q;
  assign rx_data     = rxd_q;
  assign rx_valid    = rxv_q;
  assign tx_underrun = und_q;
  assign rx_overrun  = ovr_q;
  assign frame_abort = abt_q;
  assign busy        = !ss_s;
  assign miso        = !ss_s &&
    ((LSB_FIRST != 0) ? txs_q[0] : txs_q[BitWidth-1]);
endmodule
